// File: rtl/usb_in_packer.sv
// Packs a byte stream from the compute stage into USB IN buffer packets.
// Commits on full packet, explicit flush or idle timeout; handshakes commit/ack with the USB core.
module usb_in_packer #(
  parameter int unsigned MAX_LEN = 512,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        usb_configured,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_flush,
  output logic [8:0]  buf_in_addr,
  output logic [7:0]  buf_in_data,
  output logic        buf_in_wren,
  input  logic        buf_in_ready,
  output logic        buf_in_commit,
  output logic [9:0]  buf_in_commit_len,
  input  logic        buf_in_commit_ack,
  output logic [15:0] stat_packets
);

  localparam int unsigned CW = 10;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 16;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    COMMIT  = 2'd2,
    ACK_LOW = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_cfg_m;
  logic            r_cfg_s;
  logic            r_rdy_m;
  logic            r_rdy_s;
  logic            r_ack_m;
  logic            r_ack_s;

  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_timer;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic            r_wren;
  logic            r_commit;
  logic [CW-1:0]   r_commit_len;
  logic [SW-1:0]   r_stat;

  logic            w_in_ready;
  logic            w_accept;
  logic [CW-1:0]   w_count_nxt;
  logic            w_full;
  logic            w_flush;
  logic            w_timeout;
  logic            w_fill_done;
  logic            w_enter_commit;
  logic            w_leave_commit;

  // Two-flop synchronizers for the USB-core status lines
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_cfg_m <= 1'b0;
      r_cfg_s <= 1'b0;
      r_rdy_m <= 1'b0;
      r_rdy_s <= 1'b0;
      r_ack_m <= 1'b0;
      r_ack_s <= 1'b0;
    end else begin
      r_cfg_m <= usb_configured;
      r_cfg_s <= r_cfg_m;
      r_rdy_m <= buf_in_ready;
      r_rdy_s <= r_rdy_m;
      r_ack_m <= buf_in_commit_ack;
      r_ack_s <= r_ack_m;
    end
  end

  // Gating with cfg_s keeps a byte from being taken into a packet that is about to be discarded
  assign w_in_ready  = (r_state == FILL) && r_cfg_s && (r_count < CW'(MAX_LEN));
  assign w_accept    = in_valid && w_in_ready;
  assign w_count_nxt = r_count + CW'(w_accept);
  assign w_full      = (w_count_nxt == CW'(MAX_LEN));
  assign w_flush     = in_flush && (w_count_nxt != '0);
  assign w_timeout   = (r_timer >= TW'(TIMEOUT)) && (r_count != '0);
  assign w_fill_done = w_full || w_flush || w_timeout;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (r_cfg_s && r_rdy_s) begin
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        if (w_fill_done) begin
          w_state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        if (r_ack_s) begin
          w_state_nxt = ACK_LOW;
        end
      end
      ACK_LOW: begin
        if (!r_ack_s) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (!r_cfg_s) begin
      w_state_nxt = IDLE;
    end
  end

  assign w_enter_commit = (r_state == FILL) && (w_state_nxt == COMMIT);
  assign w_leave_commit = (r_state == COMMIT) && (w_state_nxt == ACK_LOW);

  // Byte write port: one-cycle strobe in the cycle after the accept
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_wren <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_wren <= w_accept;
      if (w_accept) begin
        r_addr <= r_count[AW-1:0];
        r_data <= in_data;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_count <= '0;
    end else if (r_state == IDLE) begin
      r_count <= '0;
    end else if (r_state == FILL) begin
      r_count <= w_count_nxt;
    end
  end

  // Idle timer saturates at TIMEOUT so it never wraps while waiting in FILL
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_timer <= '0;
    end else if ((r_state != FILL) || w_accept) begin
      r_timer <= '0;
    end else if ((r_count != '0) && (r_timer < TW'(TIMEOUT))) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Commit is raised one cycle after entering COMMIT, so it trails the last wren
  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_commit     <= 1'b0;
      r_commit_len <= '0;
      r_stat       <= '0;
    end else begin
      r_commit <= (r_state == COMMIT) && (w_state_nxt == COMMIT);
      if (w_enter_commit) begin
        r_commit_len <= w_count_nxt;
      end
      if (w_leave_commit) begin
        r_stat <= r_stat + SW'(1);
      end
    end
  end

  assign in_ready          = w_in_ready;
  assign buf_in_addr       = r_addr;
  assign buf_in_data       = r_data;
  assign buf_in_wren       = r_wren;
  assign buf_in_commit     = r_commit;
  assign buf_in_commit_len = r_commit_len;
  assign stat_packets      = r_stat;

endmodule

// File: tb/tb_usb_in_packer.sv
// Directed bench for usb_in_packer with MAX_LEN=4, TIMEOUT=100.
module tb_usb_in_packer;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic        usb_configured;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_flush;
  logic [8:0]  buf_in_addr;
  logic [7:0]  buf_in_data;
  logic        buf_in_wren;
  logic        buf_in_ready;
  logic        buf_in_commit;
  logic [9:0]  buf_in_commit_len;
  logic        buf_in_commit_ack;
  logic [15:0] stat_packets;

  int checks = 0;
  int errors = 0;

  logic [8:0] wr_addr[$];
  logic [7:0] wr_data[$];
  int         n_commits  = 0;
  int         n_overlap  = 0;
  int         n_zero_len = 0;
  logic       commit_q   = 1'b0;

  usb_in_packer #(.MAX_LEN(4), .TIMEOUT(100)) dut (
    .clk_50            (clk_50),
    .reset             (reset),
    .usb_configured    (usb_configured),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_flush          (in_flush),
    .buf_in_addr       (buf_in_addr),
    .buf_in_data       (buf_in_data),
    .buf_in_wren       (buf_in_wren),
    .buf_in_ready      (buf_in_ready),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .stat_packets      (stat_packets)
  );

  always #5 clk_50 = ~clk_50;

  // Buffer-side observer, sampled mid-cycle
  always @(negedge clk_50) begin
    if (buf_in_wren) begin
      wr_addr.push_back(buf_in_addr);
      wr_data.push_back(buf_in_data);
    end
    if (buf_in_commit && !commit_q) begin
      n_commits++;
      if (buf_in_commit_len == 10'd0) n_zero_len++;
    end
    if (buf_in_commit && buf_in_wren) n_overlap++;
    commit_q = buf_in_commit;
  end

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(in_ready), 1);
  endtask

  task automatic wait_commit(input string tag, input logic level);
    int n = 0;
    while (buf_in_commit !== level && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(buf_in_commit), 32'(level));
  endtask

  task automatic send_byte(input logic [7:0] d, input logic fl);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_flush = fl;
    while (in_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  task automatic pulse_flush();
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
  endtask

  task automatic ack_cycle(input string tag);
    buf_in_commit_ack = 1'b1;
    wait_commit(tag, 1'b0);
    buf_in_commit_ack = 1'b0;
    repeat (4) tick();
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [8:0] a, input logic [7:0] d);
    if (idx < wr_addr.size()) begin
      chk({tag, "_addr"}, 32'(wr_addr[idx]), 32'(a));
      chk({tag, "_data"}, 32'(wr_data[idx]), 32'(d));
    end else begin
      chk({tag, "_present"}, 32'(wr_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int base;
    int n;
    int sz;

    reset = 1'b1;
    usb_configured = 1'b1;
    buf_in_ready = 1'b1;
    buf_in_commit_ack = 1'b0;
    in_data = 8'h00;
    in_valid = 1'b0;
    in_flush = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wren", 32'(buf_in_wren), 0);
    chk("rst_commit", 32'(buf_in_commit), 0);
    chk("rst_addr", 32'(buf_in_addr), 0);
    chk("rst_data", 32'(buf_in_data), 0);
    chk("rst_len", 32'(buf_in_commit_len), 0);
    chk("rst_stat", 32'(stat_packets), 0);
    reset = 1'b0;

    // Three bytes then a flush pulse
    wait_ready("t1_ready");
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    pulse_flush();
    wait_commit("t1_commit", 1'b1);
    chk("t1_len", 32'(buf_in_commit_len), 3);
    chk("t1_nwr", 32'(wr_addr.size()), 3);
    chk_log("t1_w0", 0, 9'd0, 8'h11);
    chk_log("t1_w1", 1, 9'd1, 8'h22);
    chk_log("t1_w2", 2, 9'd2, 8'h33);
    chk("t1_stat_pre", 32'(stat_packets), 0);
    ack_cycle("t1_ack");
    chk("t1_stat", 32'(stat_packets), 1);

    // Five bytes back-to-back against MAX_LEN=4
    wr_addr.delete();
    wr_data.delete();
    wait_ready("t2_ready");
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'hA0 + i);
      in_valid = 1'b1;
      chk("t2_rdy_b2b", 32'(in_ready), 1);
      tick();
    end
    in_data = 8'hA4;
    chk("t2_stall", 32'(in_ready), 0);
    wait_commit("t2_commit", 1'b1);
    chk("t2_len", 32'(buf_in_commit_len), 4);
    chk("t2_nwr", 32'(wr_addr.size()), 4);
    chk_log("t2_w0", 0, 9'd0, 8'hA0);
    chk_log("t2_w3", 3, 9'd3, 8'hA3);
    buf_in_commit_ack = 1'b1;
    wait_commit("t2_ack", 1'b0);
    chk("t2_stall_ack", 32'(in_ready), 0);
    buf_in_commit_ack = 1'b0;
    wait_ready("t2_refill");
    tick();
    in_valid = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    pulse_flush();
    wait_commit("t2_commit5", 1'b1);
    chk("t2_len5", 32'(buf_in_commit_len), 1);
    chk_log("t2_w5", 0, 9'd0, 8'hA4);
    ack_cycle("t2_ack5");
    chk("t2_stat", 32'(stat_packets), 3);

    // Idle timeout commits a single byte
    wait_ready("t3_ready");
    send_byte(8'h5A, 1'b0);
    n = 0;
    while (buf_in_commit !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("t3_latency_ok", 32'((n >= 100) && (n <= 104)), 1);
    chk("t3_len", 32'(buf_in_commit_len), 1);
    ack_cycle("t3_ack");
    chk("t3_stat", 32'(stat_packets), 4);

    // Empty packet: neither timeout nor flush commits
    wait_ready("t4_ready");
    base = n_commits;
    repeat (150) tick();
    pulse_flush();
    repeat (5) tick();
    chk("t4_no_commit", 32'(n_commits - base), 0);
    chk("t4_commit_lo", 32'(buf_in_commit), 0);
    wr_addr.delete();
    wr_data.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b1);
    wait_commit("t4_commit", 1'b1);
    chk("t4_len", 32'(buf_in_commit_len), 2);
    chk_log("t4_w1", 1, 9'd1, 8'h02);
    ack_cycle("t4_ack");
    chk("t4_stat", 32'(stat_packets), 5);

    // Configuration loss discards the partial packet
    wait_ready("t5_ready");
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    base = n_commits;
    usb_configured = 1'b0;
    repeat (3) tick();
    chk("t5_rdy_drop", 32'(in_ready), 0);
    repeat (20) tick();
    chk("t5_no_commit", 32'(n_commits - base), 0);
    chk("t5_stat", 32'(stat_packets), 5);
    usb_configured = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    wait_ready("t5_reready");
    send_byte(8'h77, 1'b1);
    wait_commit("t5_commit", 1'b1);
    chk("t5_len", 32'(buf_in_commit_len), 1);
    chk_log("t5_w0", 0, 9'd0, 8'h77);
    ack_cycle("t5_ack");
    chk("t5_stat2", 32'(stat_packets), 6);

    // Slow acknowledge and long-held acknowledge
    wait_ready("t6_ready");
    send_byte(8'h99, 1'b1);
    wait_commit("t6_commit", 1'b1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (buf_in_commit === 1'b1) n++;
    end
    chk("t6_commit_hold", 32'(n), 20);
    buf_in_commit_ack = 1'b1;
    n = 0;
    while (buf_in_commit !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    chk("t6_commit_fall", 32'(buf_in_commit), 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (in_ready === 1'b1) n++;
    end
    chk("t6_no_fill_ack_hi", 32'(n), 0);
    chk("t6_stat", 32'(stat_packets), 7);
    buf_in_commit_ack = 1'b0;
    wait_ready("t6_refill");

    // Reset mid-packet abandons it
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    base = n_commits;
    reset = 1'b1;
    tick();
    sz = wr_addr.size();
    in_valid = 1'b1;
    in_flush = 1'b1;
    repeat (10) tick();
    in_valid = 1'b0;
    in_flush = 1'b0;
    chk("t7_no_wren", 32'(wr_addr.size() - sz), 0);
    chk("t7_no_commit", 32'(n_commits - base), 0);
    chk("t7_stat", 32'(stat_packets), 0);
    chk("t7_len", 32'(buf_in_commit_len), 0);
    chk("t7_in_ready", 32'(in_ready), 0);
    reset = 1'b0;
    repeat (5) tick();

    chk("commit_wren_overlap", 32'(n_overlap), 0);
    chk("commit_zero_len", 32'(n_zero_len), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_in_packer.md
USB_IN_PACKER -- requirements
Module: usb_in_packer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 512, giving the packet size in bytes that forces a commit (range 1..512).
REQ-002 SHALL have parameter TIMEOUT, default 50000, giving the idle clk_50 cycles after the last byte that force a partial-packet commit (1 ms).
REQ-003 SHALL have port clk_50  input  1  sole clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port usb_configured  input  1  USB configured status, asynchronous to clk_50.
REQ-006 SHALL have port in_data  input  8  result byte from the upstream compute stage.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  packer accepts in_data this cycle.
REQ-009 SHALL have port in_flush  input  1  single-cycle pulse requesting immediate commit of a partial packet.
REQ-010 SHALL have port buf_in_addr  output  9  USB IN buffer write address.
REQ-011 SHALL have port buf_in_data  output  8  USB IN buffer write data.
REQ-012 SHALL have port buf_in_wren  output  1  USB IN buffer write strobe.
REQ-013 SHALL have port buf_in_ready  input  1  IN buffer free, asynchronous.
REQ-014 SHALL have port buf_in_commit  output  1  commit request.
REQ-015 SHALL have port buf_in_commit_len  output  10  committed byte count.
REQ-016 SHALL have port buf_in_commit_ack  input  1  commit acknowledge, asynchronous.
REQ-017 SHALL have port stat_packets  output  16  count of committed packets, wraps 0xFFFF->0.

Function
REQ-018 SHALL pass usb_configured, buf_in_ready and buf_in_commit_ack each through a 2-flop synchronizer (cfg_s, rdy_s, ack_s); all decisions use the synchronized copies.
REQ-019 SHALL implement states IDLE, FILL, COMMIT and ACK_LOW.
REQ-020 IDLE: SHALL go to FILL when cfg_s & rdy_s, and SHALL clear the byte count to 0.
REQ-021 FILL: in_ready SHALL equal (count < MAX_LEN) and SHALL be 0 in every other state.
REQ-022 SHALL accept a byte on any cycle N with in_valid & in_ready, and in cycle N+1 SHALL drive buf_in_wren=1 for exactly one cycle with buf_in_addr=count and buf_in_data=in_data; count then increments by 1.
REQ-023 FILL->COMMIT SHALL occur when the count reaches MAX_LEN, on in_flush with count>0, or when the timer reaches TIMEOUT with count>0.
REQ-024 An accept coinciding with in_flush SHALL include the byte in the packet (commit length = old count+1).
REQ-025 in_flush with count=0 and no simultaneous accept SHALL be ignored.
REQ-026 The timer SHALL clear on every accept and SHALL count only in FILL with count>0.
REQ-027 buf_in_commit_len SHALL latch the count on entry to COMMIT and hold it until the next commit.
REQ-028 buf_in_commit SHALL rise no earlier than 1 cycle after the final buf_in_wren pulse and SHALL stay high in COMMIT until ack_s=1; buf_in_commit SHALL then be 0 and the state goes to ACK_LOW.
REQ-029 ACK_LOW: SHALL return to IDLE when ack_s=0; stat_packets SHALL increment once per packet, on leaving COMMIT.
REQ-030 cfg_s=0 in any state SHALL go to IDLE next cycle, drop buf_in_commit and in_ready, discard buffered bytes, and leave stat_packets unchanged for the discarded packet.
REQ-031 Bytes offered outside FILL SHALL be back-pressured (in_ready=0) and never dropped silently.

Reset
REQ-032 While reset=1: state IDLE; count, timer, synchronizers and stat_packets =0; in_ready, buf_in_wren, buf_in_commit =0; buf_in_addr, buf_in_data, buf_in_commit_len =0.
REQ-033 Reset asserted mid-packet or mid-commit SHALL abandon the packet with no further wren/commit pulses.

Verification
REQ-034 Configured and ready; send 3 bytes 0x11,0x22,0x33 then pulse in_flush -> wren at addr 0,1,2 with those data; commit with len=3; after ack high->low, stat_packets=1.
REQ-035 MAX_LEN=4; stream 5 bytes back-to-back -> first 4 committed with len=4; 5th stalled (in_ready=0) until the next FILL, then written at addr 0.
REQ-036 TIMEOUT=100; send 1 byte then idle -> commit asserted about 100 cycles after the accept with len=1; no commit with count=0 while idle.
REQ-037 in_flush with count=0 -> no commit; in_flush coincident with a 2nd byte accept -> len=2.
REQ-038 Drop usb_configured after 2 bytes -> IDLE within 3 cycles; no commit; stat_packets unchanged; re-configure and send 1 byte -> written at addr 0.
REQ-039 Hold buf_in_commit_ack low for 20 cycles -> buf_in_commit stays high throughout; raise ack -> commit falls; ack held high -> no new FILL until ack is low.
